// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a hard-wired zero register, optional
// same-cycle write bypass and a per-register pending (scoreboard) bit.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic [NUM_RD*ADDR_W-1:0] Rn,
    output logic [NUM_RD*DATA_W-1:0] Rd,
    output logic [NUM_RD-1:0]        Busy,
    input  logic                     Write,
    input  logic [ADDR_W-1:0]        Wn,
    input  logic [DATA_W-1:0]        Wd,
    input  logic                     Rsv,
    input  logic [ADDR_W-1:0]        RsvN,
    input  logic                     Flush
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  pend_r;
    logic [DEPTH-1:0]  pend_nxt_s;

    // Register 0 is architecturally constant, so any index of zero is inert.
    function automatic logic live(input logic [ADDR_W-1:0] idx);
        return |idx;
    endfunction

    // Register contents: async clear, write on rising edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_r[k] <= '0;
            end
        end else if (Write && live(Wn)) begin
            regs_r[Wn] <= Wd;
        end
    end

    // Pending-bit next state; cascade order gives Rsv > Flush > Write-clear.
    always_comb begin
        pend_nxt_s = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (j == 0) begin
                pend_nxt_s[j] = 1'b0;
            end else if (Rsv && (RsvN == ADDR_W'(j))) begin
                pend_nxt_s[j] = 1'b1;
            end else if (Flush) begin
                pend_nxt_s[j] = 1'b0;
            end else if (Write && (Wn == ADDR_W'(j))) begin
                pend_nxt_s[j] = 1'b0;
            end else begin
                pend_nxt_s[j] = pend_r[j];
            end
        end
    end

    // Pending-bit register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        logic [ADDR_W-1:0] idx_s;
        logic              hit_s;
        logic              rsv_hit_s;
        logic [DATA_W-1:0] rd_s;
        logic              busy_s;

        assign idx_s = Rn[g*ADDR_W +: ADDR_W];

        // Per-port read mux; forwarding is suppressed while reset is held so
        // the outputs stay zero throughout reset.
        always_comb begin
            hit_s     = (BYPASS != 0) && Resetn && Write && live(Wn) && (Wn == idx_s);
            rsv_hit_s = Rsv && (RsvN == idx_s);
            if (!live(idx_s)) begin
                rd_s   = '0;
                busy_s = 1'b0;
            end else if (hit_s) begin
                rd_s   = Wd;
                busy_s = rsv_hit_s ? pend_r[idx_s] : 1'b0;
            end else begin
                rd_s   = regs_r[idx_s];
                busy_s = pend_r[idx_s];
            end
        end

        assign Rd[g*DATA_W +: DATA_W] = rd_s;
        assign Busy[g]                = busy_s;
    end

endmodule
